// File: rtl/ones_counter_pkg.sv
// rtl/ones_counter_pkg.sv - shared widths, mode encodings and width helper for the ones counter
package ones_counter_pkg;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  localparam int DEF_BIT_WIDTH   = 32;
  localparam int DEF_CHUNK_WIDTH = 8;
  localparam int DEF_ACC_WIDTH   = 16;

  // Bits needed to index n values, i.e. ceil(log2(n)).
  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ones_counter_pipe_if.sv
// rtl/ones_counter_pipe_if.sv - word-in / count-out handshake bundle for ones_counter_pipe
interface ones_counter_pipe_if
  import ones_counter_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) ();
  localparam int CW = clog2_w(BIT_WIDTH + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] word_in;
  logic                 mode;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        count_out;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_sat;
  logic                 out_last;

  modport master (
    output in_valid, word_in, mode, in_last, out_ready,
    input  in_ready, out_valid, count_out, acc_out, acc_sat, out_last
  );

  modport slave (
    input  in_valid, word_in, mode, in_last, out_ready,
    output in_ready, out_valid, count_out, acc_out, acc_sat, out_last
  );
endinterface

// File: rtl/chunk_popcount.sv
// rtl/chunk_popcount.sv - combinational ones count of a single chunk slice
module chunk_popcount
  import ones_counter_pkg::*;
#(
  parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
  parameter int COUNT_WIDTH = clog2_w(CHUNK_WIDTH + 1)
) (
  input  logic [CHUNK_WIDTH-1:0] chunk_in,
  output logic [COUNT_WIDTH-1:0] count_out
);

  always_comb begin
    count_out = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      count_out = count_out + COUNT_WIDTH'(chunk_in[i]);
    end
  end

endmodule

// File: rtl/ones_counter_pipe.sv
// rtl/ones_counter_pipe.sv - two-stage pipelined ones/zeros counter with optional frame accumulator
// (accumulator built only when ONES_COUNTER_ACCUM_EN is defined)
module ones_counter_pipe
  import ones_counter_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  ones_counter_pipe_if.slave bus
);
  localparam int CW  = clog2_w(BIT_WIDTH + 1);
  localparam int NCH = BIT_WIDTH / CHUNK_WIDTH;
  localparam int CKW = clog2_w(CHUNK_WIDTH + 1);

  logic                     adv;
  logic [NCH-1:0][CKW-1:0]  chunk_cnt;
  logic [NCH-1:0][CKW-1:0]  s1_cnt_q, s1_cnt_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic                     s1_mode_q, s1_mode_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [CW-1:0]            count_q, count_d;
  logic [CW-1:0]            ones_sum, word_cnt;

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    chunk_popcount #(
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .COUNT_WIDTH (CKW)
    ) u_chunk (
      .chunk_in  (bus.word_in[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count_out (chunk_cnt[g])
    );
  end

  assign adv          = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = adv;

  // Zeros of the word equal ones of its inverse, so derive that count from the ones sum.
  always_comb begin
    ones_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      ones_sum = ones_sum + CW'(s1_cnt_q[i]);
    end
    word_cnt = (s1_mode_q == MODE_ZEROS) ? (CW'(BIT_WIDTH) - ones_sum) : ones_sum;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    s1_cnt_d    = s1_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    if (adv) begin
      s1_valid_d  = bus.in_valid;
      s1_last_d   = bus.in_last;
      s1_mode_d   = bus.mode;
      s1_cnt_d    = chunk_cnt;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        count_d    = word_cnt;
        out_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MODE_ONES;
      s1_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_cnt_q    <= s1_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.count_out = count_q;

`ifdef ONES_COUNTER_ACCUM_EN
  localparam int AW1 = ACC_WIDTH + 1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic                 frame_start_q, frame_start_d;
  logic [AW1-1:0]       acc_sum;

  // frame_start marks that the next valid beat opens a new frame and must not add to acc_q.
  always_comb begin
    acc_d         = acc_q;
    sat_d         = sat_q;
    frame_start_d = frame_start_q;
    acc_sum       = (frame_start_q ? '0 : {1'b0, acc_q}) + AW1'(word_cnt);
    if (adv && s1_valid_q) begin
      frame_start_d = s1_last_q;
      if (acc_sum[ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_WIDTH-1:0];
        sat_d = frame_start_q ? 1'b0 : sat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q         <= '0;
      sat_q         <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.acc_out = acc_q;
  assign bus.acc_sat = sat_q;
`else
  assign bus.acc_out = '0;
  assign bus.acc_sat = 1'b0;
`endif

endmodule
